// File: rtl/itcm_fetch_resp_pkg.sv
// Shared constants for the instruction TCM fetch responder.
package itcm_fetch_resp_pkg;

    localparam int unsigned ITCM_PC_SIZE = 32;
    localparam int unsigned ITCM_XLEN    = 32;
    localparam int unsigned ITCM_AW      = 12;
    localparam logic [31:0] ITCM_BASE    = 32'h0000_0000;

    // Response entry: {instr, misalgn, buserr}
    localparam int unsigned RSP_ENTRY_W  = ITCM_XLEN + 2;

endpackage

// File: rtl/itcm_sram.sv
// Behavioural 2^AW x XLEN SRAM, one read and one write port, read-first, registered read.
module itcm_sram #(
    parameter int unsigned AW   = 12,
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] mem [1 << AW];

    // Both updates are non-blocking, so a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/itcm_fetch_resp.sv
// Instruction TCM fetch responder: 1-cycle SRAM read, 2-entry response FIFO, flush and error flags.
module itcm_fetch_resp
    import itcm_fetch_resp_pkg::*;
#(
    parameter int unsigned        PC_SIZE   = ITCM_PC_SIZE,
    parameter int unsigned        XLEN      = ITCM_XLEN,
    parameter int unsigned        AW        = ITCM_AW,
    parameter logic [PC_SIZE-1:0] BASE_ADDR = PC_SIZE'(ITCM_BASE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [PC_SIZE-1:0] req_pc,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [XLEN-1:0]    rsp_instr,
    output logic               rsp_misalgn,
    output logic               rsp_buserr,
    input  logic               flush,
    input  logic               init_we,
    input  logic [AW-1:0]      init_addr,
    input  logic [XLEN-1:0]    init_wdata
);

    localparam int unsigned EntryW = XLEN + 2;

    logic                rdy_q;
    logic                inflight_q;
    logic                inflight_kill_q;
    logic                sb_misalgn_q;
    logic                sb_buserr_q;
    logic [1:0]          cnt_q;
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [EntryW-1:0]   fifo_q [2];

    logic [PC_SIZE-1:0]  offset;
    logic                misalgn;
    logic                buserr;
    logic                accept;
    logic                sram_re;
    logic [XLEN-1:0]     sram_rdata;
    logic                arrive;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [EntryW-1:0]   arrive_entry;
    logic [EntryW-1:0]   out_entry;

    // BASE_ADDR is window-aligned, so any address below it wraps into the high offset bits.
    assign offset  = req_pc - BASE_ADDR;
    assign misalgn = |req_pc[1:0];
    assign buserr  = |offset[PC_SIZE-1:AW+2];

    assign req_ready = rdy_q && !flush && (({1'b0, cnt_q} + {2'b00, inflight_q}) < 3'd2);
    assign accept    = req_valid && req_ready;
    assign sram_re   = accept && !misalgn && !buserr;

    itcm_sram #(
        .AW   (AW),
        .XLEN (XLEN)
    ) u_sram (
        .clk   (clk),
        .re    (sram_re),
        .raddr (offset[AW+1:2]),
        .rdata (sram_rdata),
        .we    (init_we),
        .waddr (init_addr),
        .wdata (init_wdata)
    );

    assign arrive       = inflight_q && !inflight_kill_q && !flush;
    assign arrive_entry = {(sb_misalgn_q || sb_buserr_q) ? '0 : sram_rdata,
                           sb_misalgn_q, sb_buserr_q};
    assign fifo_empty   = (cnt_q == 2'd0);

    always_comb begin
        out_entry = '0;
        rsp_valid = !flush && (!fifo_empty || arrive);
        if (rsp_valid) begin
            out_entry = fifo_empty ? arrive_entry : fifo_q[rd_ptr_q];
        end
    end

    assign rsp_instr   = out_entry[EntryW-1:2];
    assign rsp_misalgn = out_entry[1];
    assign rsp_buserr  = out_entry[0];

    // A bypassed word only lands in the FIFO if it cannot leave this cycle.
    assign pop  = rsp_valid && rsp_ready && !fifo_empty;
    assign push = arrive && (!fifo_empty || !rsp_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q           <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_kill_q <= 1'b0;
            sb_misalgn_q    <= 1'b0;
            sb_buserr_q     <= 1'b0;
            cnt_q           <= 2'd0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            fifo_q[0]       <= '0;
            fifo_q[1]       <= '0;
        end else begin
            rdy_q           <= 1'b1;
            inflight_q      <= accept;
            inflight_kill_q <= flush && inflight_q;
            if (accept) begin
                sb_misalgn_q <= misalgn;
                sb_buserr_q  <= buserr;
            end
            if (flush) begin
                cnt_q    <= 2'd0;
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    fifo_q[wr_ptr_q] <= arrive_entry;
                    wr_ptr_q         <= !wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= !rd_ptr_q;
                end
                case ({push, pop})
                    2'b10:   cnt_q <= cnt_q + 2'd1;
                    2'b01:   cnt_q <= cnt_q - 2'd1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && cnt_q == 2'd2));

endmodule
